sketch_bank_rmw: RTL and testbench

SKETCH_BANK_RMW -- requirements
Module: sketch_bank_rmw

---
 rtl/sketch_pkg.sv | 35 +++
 rtl/sketch_rmw_lane.sv | 77 +++++++
 rtl/sketch_bank_rmw.sv | 104 ++++++++++
 tb/tb_sketch_bank_rmw.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sketch_pkg.sv
// rtl/sketch_pkg.sv - shared types and counter adder for the sketch bank.
// SKETCH_SAT_EN selects a saturating adder; without it the adder wraps.
package sketch_pkg;

  localparam int HW_MAX = 16;
  localparam int DW_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [HW_MAX-1:0] addr;
    logic [DW_MAX-1:0] value;
  } stage_t;

  // Operands are already below 2^dw, so a wider-than-dw carry shows up as s > lim,
  // and at dw=64 as a wrapped sum smaller than an operand.
  function automatic logic [DW_MAX-1:0] sketch_add(input logic [DW_MAX-1:0] a,
                                                   input logic [DW_MAX-1:0] b,
                                                   input int             dw);
    logic [DW_MAX-1:0] s;
    logic [DW_MAX-1:0] lim;
    s   = a + b;
    lim = (64'd1 << dw) - 64'd1;
`ifdef SKETCH_SAT_EN
    if (s > lim || s < a) return lim;
`endif
    return s & lim;
  endfunction

endpackage

// File: rtl/sketch_rmw_lane.sv
// rtl/sketch_rmw_lane.sv - one counter bank: dual-port RAM, update RMW pipeline with
// forwarding, registered query read path.
module sketch_rmw_lane
  import sketch_pkg::*;
#(
  parameter int DW = 32,
  parameter int HW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_upd_acc,
  input  logic [HW-1:0] i_upd_addr,
  input  logic [DW-1:0] i_upd_inc,
  input  logic          i_clr_we,
  input  logic [HW-1:0] i_clr_addr,
  input  logic [HW-1:0] i_qry_addr,
  output logic [DW-1:0] o_qry_data,
  output logic          o_pipe_busy
);

  logic [DW-1:0] r_mem [2**HW];
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_qry_ram;
  logic [DW-1:0] r_qry_out;
  stage_t        r_s1;
  stage_t        r_s2;
  logic              r_fwd_hit;
  logic [DW_MAX-1:0] r_fwd_val;

  logic [HW_MAX-1:0] w_upd_addr;
  logic [DW_MAX-1:0] w_old;
  logic [DW_MAX-1:0] w_new;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_we;
  logic [HW-1:0]     w_waddr;
  logic [DW-1:0]     w_wdata;

  assign w_upd_addr = HW_MAX'(i_upd_addr);
  assign w_old      = r_fwd_hit ? r_fwd_val : DW_MAX'(r_rd_data);
  assign w_new      = sketch_add(w_old, r_s1.value, DW);
  assign w_hit1     = r_s1.valid && (r_s1.addr == w_upd_addr);
  assign w_hit2     = r_s2.valid && (r_s2.addr == w_upd_addr);
  assign w_we       = i_clr_we | r_s2.valid;
  assign w_waddr    = i_clr_we ? i_clr_addr : r_s2.addr[HW-1:0];
  assign w_wdata    = i_clr_we ? '0 : r_s2.value[DW-1:0];
  assign o_qry_data  = r_qry_out;
  assign o_pipe_busy = r_s1.valid | r_s2.valid;

  // Reads return pre-write data on a same-cycle collision; forwarding covers that case.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd_data <= r_mem[i_upd_addr];
    r_qry_ram <= r_mem[i_qry_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1.valid <= 1'b0;
      r_s2.valid <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_qry_out  <= '0;
    end else begin
      r_s1.valid <= i_upd_acc;
      r_s1.addr  <= w_upd_addr;
      r_s1.value <= DW_MAX'(i_upd_inc);
      r_s2.valid <= r_s1.valid;
      r_s2.addr  <= r_s1.addr;
      r_s2.value <= w_new;
      // Compute stage is younger than the write stage, so it wins.
      r_fwd_hit  <= w_hit1 | w_hit2;
      r_fwd_val  <= w_hit1 ? w_new : r_s2.value;
      r_qry_out  <= r_qry_ram;
    end
  end

endmodule

// File: rtl/sketch_bank_rmw.sv
// rtl/sketch_bank_rmw.sv - NB-row count sketch with update RMW, queries and full clear.
// Adder behaviour follows SKETCH_SAT_EN (saturate when defined, wrap otherwise).
module sketch_bank_rmw
  import sketch_pkg::*;
#(
  parameter int NB = 4,
  parameter int DW = 32,
  parameter int HW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid_i,
  output logic               upd_ready_o,
  input  logic [NB*HW-1:0]   upd_addr_i,
  input  logic [DW-1:0]      upd_inc_i,
  input  logic               qry_valid_i,
  input  logic [NB*HW-1:0]   qry_addr_i,
  output logic               qry_valid_o,
  output logic [NB*DW-1:0]   qry_data_o,
  input  logic               clr_start_i,
  output logic               clr_busy_o
);

  localparam logic [HW-1:0] LAST_ADDR = '1;

  state_t        r_state;
  logic [HW-1:0] r_clr_addr;
  logic          r_upd_ready;
  logic          r_busy;
  logic          r_qv1;
  logic          r_qv2;

  logic          w_acc;
  logic          w_clr_we;
  logic [NB-1:0] w_lane_busy;

  assign w_acc       = upd_valid_i & r_upd_ready;
  assign w_clr_we    = (r_state == ST_CLEAR);
  assign upd_ready_o = r_upd_ready;
  assign clr_busy_o  = r_busy;
  assign qry_valid_o = r_qv2;

  for (genvar k = 0; k < NB; k++) begin : g_lane
    sketch_rmw_lane #(
      .DW(DW),
      .HW(HW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_upd_acc  (w_acc),
      .i_upd_addr (upd_addr_i[k*HW +: HW]),
      .i_upd_inc  (upd_inc_i),
      .i_clr_we   (w_clr_we),
      .i_clr_addr (r_clr_addr),
      .i_qry_addr (qry_addr_i[k*HW +: HW]),
      .o_qry_data (qry_data_o[k*DW +: DW]),
      .o_pipe_busy(w_lane_busy[k])
    );
  end

  // Reset lands in CLEAR so the RAM contents are always defined afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clr_addr  <= '0;
      r_upd_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_qv1       <= 1'b0;
      r_qv2       <= 1'b0;
    end else begin
      r_qv1 <= qry_valid_i;
      r_qv2 <= r_qv1;
      case (r_state)
        ST_IDLE: begin
          if (clr_start_i) begin
            r_state     <= ST_DRAIN;
            r_upd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!(|w_lane_busy)) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state     <= ST_IDLE;
            r_upd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + HW'(1);
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sketch_bank_rmw.sv
// tb/tb_sketch_bank_rmw.sv - randomized and directed bench against a sum-of-updates model.
module tb_sketch_bank_rmw;

  localparam int NB = 4;
  localparam int DW = 32;
  localparam int HW = 10;
  localparam int DEPTH = 1 << HW;
  localparam longint unsigned MAXV = (64'd1 << DW) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             upd_valid_i;
  logic             upd_ready_o;
  logic [NB*HW-1:0] upd_addr_i;
  logic [DW-1:0]    upd_inc_i;
  logic             qry_valid_i;
  logic [NB*HW-1:0] qry_addr_i;
  logic             qry_valid_o;
  logic [NB*DW-1:0] qry_data_o;
  logic             clr_start_i;
  logic             clr_busy_o;

  sketch_bank_rmw #(.NB(NB), .DW(DW), .HW(HW)) dut (
    .clk(clk), .rst(rst),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_addr_i(upd_addr_i), .upd_inc_i(upd_inc_i),
    .qry_valid_i(qry_valid_i), .qry_addr_i(qry_addr_i),
    .qry_valid_o(qry_valid_o), .qry_data_o(qry_data_o),
    .clr_start_i(clr_start_i), .clr_busy_o(clr_busy_o)
  );

  typedef struct { int edge_n; logic [NB*HW-1:0] addr; logic [DW-1:0] inc; } pend_t;
  typedef struct { int due; logic [NB*DW-1:0] data; logic chk; } exp_t;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  logic [DW-1:0]    mdl [NB][DEPTH];
  pend_t            pend_q[$];
  exp_t             exp_q[$];
  logic [NB*DW-1:0] last_q;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] old, input logic [DW-1:0] inc);
    longint unsigned s;
    s = 64'(old) + 64'(inc);
    if (s > MAXV) begin
`ifdef SKETCH_SAT_EN
      s = MAXV;
`else
      s = s - (MAXV + 1);
`endif
    end
    return DW'(s);
  endfunction

  function automatic logic [NB*HW-1:0] mk_addr(input int a0, input int a1, input int a2, input int a3);
    logic [NB*HW-1:0] r;
    r = {HW'(a3), HW'(a2), HW'(a1), HW'(a0)};
    return r;
  endfunction

  function automatic logic [NB*HW-1:0] rnd_addr(input int maxa);
    logic [NB*HW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*HW +: HW] = HW'($urandom_range(0, maxa));
    return r;
  endfunction

  task automatic model_zero();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mdl[b][a] = '0;
  endtask

  // One clock: drive, book-keep the model, take the edge, check the query output.
  task automatic cycle(input logic uv, input logic [NB*HW-1:0] ua, input logic [DW-1:0] inc,
                       input logic qv, input logic [NB*HW-1:0] qa, input logic cs);
    int e;
    logic clr_now;
    logic exp_v;
    exp_t x;
    e = edge_cnt + 1;
    while (pend_q.size() > 0 && pend_q[0].edge_n + 2 < e) begin
      for (int k = 0; k < NB; k++)
        mdl[k][pend_q[0].addr[k*HW +: HW]] = ref_add(mdl[k][pend_q[0].addr[k*HW +: HW]], pend_q[0].inc);
      void'(pend_q.pop_front());
    end
    upd_valid_i = uv; upd_addr_i = ua; upd_inc_i = inc;
    qry_valid_i = qv; qry_addr_i = qa; clr_start_i = cs;
    clr_now = cs && !clr_busy_o;
    if (qv) begin
      x.due = e + 1;
      x.chk = !clr_busy_o && !clr_now;
      for (int k = 0; k < NB; k++) x.data[k*DW +: DW] = mdl[k][qa[k*HW +: HW]];
      exp_q.push_back(x);
    end
    if (uv && upd_ready_o) pend_q.push_back('{e, ua, inc});
    if (clr_now) begin
      model_zero();
      pend_q.delete();
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
    check("qry_valid", 128'(qry_valid_o), 128'(exp_v));
    if (exp_v) begin
      last_q = qry_data_o;
      if (exp_q[0].chk) check("qry_data", 128'(qry_data_o), 128'(exp_q[0].data));
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_query(input logic [NB*HW-1:0] qa);
    cycle(1'b0, '0, '0, 1'b1, qa, 1'b0);
    idle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    upd_valid_i = 1'b0; upd_addr_i = '0; upd_inc_i = '0;
    qry_valid_i = 1'b0; qry_addr_i = '0; clr_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      check("rst_ready", 128'(upd_ready_o), 128'(0));
      check("rst_busy", 128'(clr_busy_o), 128'(1));
      check("rst_qvalid", 128'(qry_valid_o), 128'(0));
      check("rst_qdata", 128'(qry_data_o), 128'(0));
    end
    rst = 1'b0;
    model_zero();
    pend_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (clr_busy_o && n < 3000) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] sat_exp;
    do_reset(3);
    wait_clear(n);
    check("init_clear_len", 128'(n), 128'(DEPTH));
    check("idle_ready", 128'(upd_ready_o), 128'(1));
    do_query(mk_addr(5, 5, 5, 5));
    check("addr5_zero", 128'(last_q), 128'(0));

    for (int i = 1; i <= 3; i++) cycle(1'b1, mk_addr(7, 7, 7, 7), DW'(i), 1'b0, '0, 1'b0);
    repeat (3) idle();
    do_query(mk_addr(7, 7, 7, 7));
    check("b2b_addr7", 128'(last_q), 128'({4{32'd6}}));

    cycle(1'b1, mk_addr(1, 9, 20, 20), 32'd1, 1'b0, '0, 1'b0);
    cycle(1'b1, mk_addr(2, 9, 20, 20), 32'd1, 1'b0, '0, 1'b0);
    cycle(1'b1, mk_addr(1, 9, 20, 20), 32'd1, 1'b0, '0, 1'b0);
    cycle(1'b1, mk_addr(1, 9, 20, 20), 32'd1, 1'b0, '0, 1'b0);
    repeat (3) idle();
    do_query(mk_addr(1, 9, 20, 20));
    check("interleave_a", 128'(last_q), 128'({32'd4, 32'd4, 32'd4, 32'd3}));
    do_query(mk_addr(2, 9, 20, 20));
    check("interleave_b", 128'(last_q[31:0]), 128'(32'd1));

    cycle(1'b1, mk_addr(3, 3, 3, 3), 32'hFFFF_FF00, 1'b0, '0, 1'b0);
    cycle(1'b1, mk_addr(3, 3, 3, 3), 32'h0000_0200, 1'b0, '0, 1'b0);
    repeat (3) idle();
    do_query(mk_addr(3, 3, 3, 3));
`ifdef SKETCH_SAT_EN
    sat_exp = 32'hFFFF_FFFF;
`else
    sat_exp = 32'h0000_0100;
`endif
    check("overflow", 128'(last_q), 128'({4{sat_exp}}));

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_addr(3), DW'($urandom),
            $urandom_range(0, 1) == 1, rnd_addr(3), 1'b0);
    repeat (3) idle();
    for (int a = 0; a < 4; a++) do_query(mk_addr(a, a, a, a));

    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_addr(3), DW'($urandom_range(1, 100)), 1'b0, '0, 1'b0);
    cycle(1'b1, rnd_addr(3), 32'd5, 1'b0, '0, 1'b1);
    check("clr_ready_drop", 128'(upd_ready_o), 128'(0));
    check("clr_busy_rise", 128'(clr_busy_o), 128'(1));
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_addr(3), 32'd9, 1'b1, rnd_addr(3), 1'b1);
    wait_clear(n);
    check("clr_done", 128'(clr_busy_o), 128'(0));
    check("clr_len_min", 128'(n >= DEPTH - 5), 128'(1));
    for (int a = 0; a < 4; a++) begin
      do_query(mk_addr(a, a, a, a));
      check("post_clear_zero", 128'(last_q), 128'(0));
    end

    do_reset(2);
    repeat (500) idle();
    check("mid_clear_busy", 128'(clr_busy_o), 128'(1));
    do_reset(1);
    wait_clear(n);
    check("restart_clear_len", 128'(n), 128'(DEPTH));
    do_query(mk_addr(7, 9, 3, 1));
    check("restart_zero", 128'(last_q), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
